// File: rtl/tile_map_renderer.sv
// tile_map_renderer: walks the tile map one cell at a time and draws each cell as
// a TILE x TILE pixel block, with tank overlays, for the vga_adapter.
// Ports: clk, resetn (async, active low); start/busy/done frame handshake;
//        map_addr/map_rd_en/map_wall storage read; tank_pos/tank_en tank overlays;
//        x/y/colour/plot pixel writes.
module tile_map_renderer #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 16,
    parameter int ADDR_W = 8,
    parameter int TILE = 4,
    parameter int NUM_TANKS = 2,
    parameter logic [2:0] WALL_COLOUR = 3'b111,
    parameter logic [2:0] FLOOR_COLOUR = 3'b000,
    parameter logic [3*NUM_TANKS-1:0] TANK_COLOURS = 6'b100_010
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_W-1:0]           map_addr,
    output logic                        map_rd_en,
    input  logic                        map_wall,
    input  logic [NUM_TANKS*ADDR_W-1:0] tank_pos,
    input  logic [NUM_TANKS-1:0]        tank_en,
    output logic [7:0]                  x,
    output logic [6:0]                  y,
    output logic [2:0]                  colour,
    output logic                        plot
);

    localparam int CW = $clog2(GRID_W);
    localparam int RW = $clog2(GRID_H);
    localparam int TW = (TILE > 1) ? $clog2(TILE) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, DRAW, NEXT, DONE
    } state_t;

    state_t                      state;
    logic [RW-1:0]               row;
    logic [CW-1:0]               col;
    logic [TW-1:0]               px;
    logic [TW-1:0]               py;
    logic                        wall_q;
    logic [NUM_TANKS*ADDR_W-1:0] tank_pos_q;
    logic [NUM_TANKS-1:0]        tank_en_q;

    logic [ADDR_W-1:0] cell_addr;
    logic              last_px;
    logic              last_py;
    logic              last_col;
    logic              last_row;
    logic [TW-1:0]     npx;
    logic [TW-1:0]     npy;
    logic [CW-1:0]     ncol;
    logic [RW-1:0]     nrow;
    logic              wall_src;
    logic [2:0]        cell_colour;

    assign cell_addr = {row, col};

    always_comb begin
        last_px  = (px == TW'(TILE - 1));
        last_py  = (py == TW'(TILE - 1));
        last_col = (col == CW'(GRID_W - 1));
        last_row = (row == RW'(GRID_H - 1));
        npx      = last_px ? '0 : px + 1'b1;
        npy      = last_px ? py + 1'b1 : py;
        ncol     = last_col ? '0 : col + 1'b1;
        nrow     = last_col ? row + 1'b1 : row;
    end

    // The first pixel of a cell is registered on the same edge that
    // latches the wall bit, so it takes map_wall straight from storage.
    assign wall_src = (state == WAIT) ? map_wall : wall_q;

    // Walk tanks from highest index down so the lowest enabled match wins.
    always_comb begin
        cell_colour = wall_src ? WALL_COLOUR : FLOOR_COLOUR;
        for (int i = NUM_TANKS - 1; i >= 0; i--) begin
            if (tank_en_q[i] && tank_pos_q[i*ADDR_W +: ADDR_W] == cell_addr)
                cell_colour = TANK_COLOURS[3*i +: 3];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            plot       <= 1'b0;
            map_rd_en  <= 1'b0;
            map_addr   <= '0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            row        <= '0;
            col        <= '0;
            px         <= '0;
            py         <= '0;
            wall_q     <= 1'b0;
            tank_pos_q <= '0;
            tank_en_q  <= '0;
        end else begin
            map_rd_en <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= FETCH;
                        busy       <= 1'b1;
                        tank_pos_q <= tank_pos;
                        tank_en_q  <= tank_en;
                        map_rd_en  <= 1'b1;
                        map_addr   <= cell_addr;
                    end
                end
                FETCH: state <= WAIT;
                WAIT: begin
                    state  <= DRAW;
                    wall_q <= map_wall;
                    plot   <= 1'b1;
                    px     <= '0;
                    py     <= '0;
                    x      <= 8'(col * TILE);
                    y      <= 7'(row * TILE);
                    colour <= cell_colour;
                end
                DRAW: begin
                    if (last_px && last_py) begin
                        state <= NEXT;
                        plot  <= 1'b0;
                        px    <= '0;
                        py    <= '0;
                    end else begin
                        px     <= npx;
                        py     <= npy;
                        x      <= 8'(col * TILE + npx);
                        y      <= 7'(row * TILE + npy);
                        colour <= cell_colour;
                    end
                end
                NEXT: begin
                    col <= ncol;
                    row <= nrow;
                    if (last_col && last_row) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state     <= FETCH;
                        map_rd_en <= 1'b1;
                        map_addr  <= {nrow, ncol};
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    row   <= '0;
                    col   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_map_renderer.sv
// tb_tile_map_renderer: drives frames of tile_map_renderer against a
// storage model and compares every plotted pixel with a reference image.
module tb_tile_map_renderer;

    localparam int GW = 16;
    localparam int GH = 16;
    localparam int T = 4;
    localparam int NCELL = GW * GH;
    localparam int NPIX = NCELL * T * T;
    localparam int FRAME = NCELL * (T * T + 3);

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  map_addr;
    logic        map_rd_en;
    logic        map_wall = 1'b0;
    logic [15:0] tank_pos = '0;
    logic [1:0]  tank_en = '0;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;

    tile_map_renderer dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy),
        .done(done), .map_addr(map_addr), .map_rd_en(map_rd_en),
        .map_wall(map_wall), .tank_pos(tank_pos), .tank_en(tank_en),
        .x(x), .y(y), .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    bit mem [NCELL];
    always @(posedge clk) if (map_rd_en) map_wall <= mem[map_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [17:0] pq [$];
    logic [17:0] xq [$];
    int aq [$];
    int dq [$];
    int rd_first = -1;

    always @(negedge clk) begin
        if (plot) pq.push_back({x, y, colour});
        if (map_rd_en) begin
            aq.push_back(int'(map_addr));
            if (rd_first < 0) rd_first = cyc;
        end
        if (done) dq.push_back(cyc);
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                      tag, got, got, exp, exp);
    endtask

    function automatic logic [2:0] cell_col(input int a, input logic [15:0] tp,
                                            input logic [1:0] te);
        logic [5:0] tc;
        tc = 6'b100_010;
        for (int i = 0; i < 2; i++)
            if (te[i] && int'(tp[i*8 +: 8]) == a) return tc[i*3 +: 3];
        return mem[a] ? 3'b111 : 3'b000;
    endfunction

    task automatic build_exp(input logic [15:0] tp, input logic [1:0] te);
        xq.delete();
        for (int r = 0; r < GH; r++)
            for (int c = 0; c < GW; c++)
                for (int py = 0; py < T; py++)
                    for (int px = 0; px < T; px++)
                        xq.push_back({8'(c * T + px), 7'(r * T + py),
                                      cell_col(r * GW + c, tp, te)});
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    function automatic int pix_at(input int idx);
        if (idx < pq.size()) return int'(pq[idx]);
        return -1;
    endfunction

    task automatic run_frame(input string tag, input int chg_at,
                             input logic [15:0] chg_pos, input bit glitch);
        int s;
        int i;
        int errs;
        build_exp(tank_pos, tank_en);
        pq.delete();
        aq.delete();
        dq.delete();
        rd_first = -1;
        s = cyc;
        start = 1'b1;
        tick;
        start = 1'b0;
        i = 1;
        while (dq.size() == 0 && i < FRAME + 100) begin
            if (i == chg_at) tank_pos = chg_pos;
            start = glitch && (i == 50 || i == 2500 || i == 4000);
            tick;
            i++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, dq.size(), 1);
        if (dq.size() > 0) check({tag, "_done_cyc"}, dq[0] - s, FRAME + 1);
        check({tag, "_fetch0_cyc"}, rd_first - s, 1);
        check({tag, "_busy_at_done"}, busy, 1);
        tick;
        tick;
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_one_done"}, dq.size(), 1);
        check({tag, "_plots"}, pq.size(), NPIX);
        errs = 0;
        for (int k = 0; k < pq.size() && k < xq.size(); k++)
            if (pq[k] !== xq[k]) errs++;
        check({tag, "_pix_errs"}, errs, 0);
        check({tag, "_reads"}, aq.size(), NCELL);
        errs = 0;
        for (int k = 0; k < aq.size(); k++)
            if (aq[k] != k) errs++;
        check({tag, "_addr_errs"}, errs, 0);
    endtask

    initial begin
        int s;
        int i;
        repeat (3) tick;
        check("rst_busy", busy, 0);
        check("rst_plot", plot, 0);
        check("rst_xyc", {x, y, colour}, 0);
        check("rst_rd", {map_rd_en, map_addr}, 0);
        resetn = 1'b1;
        tick;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);

        // empty map, no tanks
        for (int a = 0; a < NCELL; a++) mem[a] = 1'b0;
        tank_en = 2'b00;
        run_frame("zero", -1, '0, 1'b0);
        check("zero_first", pix_at(0), 0);
        check("zero_last", pix_at(NPIX - 1), int'({8'd63, 7'd63, 3'd0}));

        // one full wall row
        for (int a = 0; a < NCELL; a++) mem[a] = (a >= 32 && a < 48);
        run_frame("walls", -1, '0, 1'b0);
        check("walls_y8", pix_at(32 * 16), int'({8'd0, 7'd8, 3'b111}));

        // tank priority over wall and over each other
        for (int a = 0; a < NCELL; a++) mem[a] = (a == 8'h21);
        tank_pos = 16'h2121;
        tank_en = 2'b11;
        run_frame("tank11", -1, '0, 1'b0);
        check("tank11_px", pix_at(33 * 16), int'({8'd4, 7'd8, 3'b010}));
        tank_en = 2'b10;
        run_frame("tank10", -1, '0, 1'b0);
        check("tank10_px", pix_at(33 * 16 + 15), int'({8'd7, 7'd11, 3'b100}));

        // random maps and tanks
        for (int f = 0; f < 2; f++) begin
            for (int a = 0; a < NCELL; a++) mem[a] = 1'($urandom_range(0, 1));
            tank_pos = 16'($urandom);
            tank_en = 2'($urandom);
            run_frame($sformatf("rand%0d", f), -1, '0, 1'b0);
        end

        // tank moves mid-frame: snapshot holds until the next frame
        for (int a = 0; a < NCELL; a++) mem[a] = 1'b0;
        tank_pos = 16'h0000;
        tank_en = 2'b01;
        run_frame("chg", 2000, 16'h0055, 1'b0);
        check("chg_old_pos", pix_at(0) & 7, 3'b010);
        run_frame("chg2", -1, '0, 1'b0);
        check("chg2_new_pos", pix_at(8'h55 * 16) & 7, 3'b010);
        check("chg2_old_gone", pix_at(0) & 7, 3'b000);

        // start pulses while busy are ignored
        tank_en = 2'b00;
        run_frame("glitch", -1, '0, 1'b1);

        // start held high: back-to-back frames
        pq.delete();
        dq.delete();
        s = cyc;
        start = 1'b1;
        i = 0;
        while (dq.size() < 2 && i < 2 * FRAME + 100) begin
            tick;
            i++;
        end
        start = 1'b0;
        check("held_dones", dq.size(), 2);
        if (dq.size() >= 2) begin
            check("held_first", dq[0] - s, FRAME + 1);
            check("held_period", dq[1] - dq[0], FRAME + 2);
        end
        check("held_plots", pq.size(), 2 * NPIX);
        repeat (3) tick;
        check("held_stop", dq.size(), 2);
        check("held_busy", busy, 0);

        // reset in the middle of drawing cell 0x37
        for (int a = 0; a < NCELL; a++) mem[a] = 1'($urandom_range(0, 1));
        tank_pos = 16'h3712;
        tank_en = 2'b11;
        aq.delete();
        dq.delete();
        start = 1'b1;
        tick;
        start = 1'b0;
        i = 0;
        while (!(plot && aq.size() > 0 && aq[$] == 8'h37) && i < FRAME) begin
            tick;
            i++;
        end
        check("rst_reached", plot, 1);
        resetn = 1'b0;
        #1;
        check("arst_plot", plot, 0);
        check("arst_busy", busy, 0);
        check("arst_xy", {x, y}, 0);
        repeat (3) tick;
        resetn = 1'b1;
        repeat (5) tick;
        check("arst_no_done", dq.size(), 0);
        check("arst_idle", {busy, plot, map_rd_en}, 0);
        run_frame("post_rst", -1, '0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tile_map_renderer.md
Name: tile_map_renderer

Overview:
- Parametrised frame renderer between the game storage and vga_adapter.
- Walks a GRID_W x GRID_H tile map, reads one wall bit per cell from storage, and plots each cell as a TILE x TILE pixel block.
- Overlays up to NUM_TANKS tank positions, each in its own colour.
- Replaces ad-hoc per-address wall plotting with a start/done frame handshake.

Parameters:
GRID_W, 16, tiles per row (power of 2)
GRID_H, 16, tiles per column (power of 2)
ADDR_W, 8, map address width = log2(GRID_W)+log2(GRID_H); address = {row, col}
TILE, 4, tile edge in pixels; GRID_W*TILE <= 160, GRID_H*TILE <= 120
NUM_TANKS, 2, number of tank overlay channels (>= 1)
WALL_COLOUR, 3'b111, colour of wall cells
FLOOR_COLOUR, 3'b000, colour of empty cells
TANK_COLOURS, 6'b100_010, packed 3 bits per tank; tank i = bits [3i+2:3i]

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  request a frame; sampled only in IDLE
busy  out  1  high from FETCH of first cell until DONE inclusive
done  out  1  one-cycle pulse, frame complete
map_addr  out  ADDR_W  cell address {row, col} to storage
map_rd_en  out  1  read strobe to storage
map_wall  in  1  wall bit, valid the cycle after map_rd_en
tank_pos  in  NUM_TANKS*ADDR_W  packed tank cell addresses
tank_en  in  NUM_TANKS  per-tank visible flag
x  out  8  pixel x to vga_adapter
y  out  7  pixel y to vga_adapter
colour  out  3  pixel colour
plot  out  1  pixel write enable

Behaviour:
- Reset (async, resetn=0): state IDLE; busy, done, plot, map_rd_en, map_addr, x, y, colour, row, col and px/py counters all 0. Takes effect immediately, including mid-frame; no done is issued for an aborted frame.
- States:
  - IDLE: start=1 at an edge -> FETCH; tank_pos and tank_en are snapshotted on the same edge. Tank inputs are ignored for the rest of the frame (no tearing).
  - FETCH (1 cycle): map_rd_en=1, map_addr={row,col} -> WAIT.
  - WAIT (1 cycle): latch map_wall into wall_q -> DRAW.
  - DRAW (TILE*TILE cycles): plot=1, x=col*TILE+px, y=row*TILE+py. px increments each cycle; when px wraps to 0, py increments. Exit on px=py=TILE-1 -> NEXT.
  - NEXT (1 cycle): plot=0; col++. If col=GRID_W-1, col wraps to 0 and row++. If this was the last cell (row=GRID_H-1, col=GRID_W-1) -> DONE, else -> FETCH.
  - DONE (1 cycle): done=1, busy=1, row=col=0 -> IDLE.
- Colour priority per cell, evaluated from the snapshot:
  1. Lowest-index enabled tank whose pos equals {row,col} uses its TANK_COLOURS slice.
  2. Otherwise wall_q=1 uses WALL_COLOUR.
  3. Otherwise FLOOR_COLOUR.
- Output timing: x, y, colour and plot are registered and change together. Outside DRAW, plot=0 while x, y and colour hold their last values.
- Timing per cell: TILE*TILE+3 cycles. With N=GRID_W*GRID_H and start seen at edge k, FETCH of cell 0 is at k+1 and done is high at cycle k+1+N*(TILE*TILE+3). Defaults give 4864 cycles.
- Handshake:
  - start while busy is ignored.
  - With start held high, the next frame begins in the IDLE cycle after DONE.
  - Exactly GRID_W*GRID_H*TILE*TILE plot pulses per frame; each pixel is written once.
- Tank addresses outside the grid never match a cell and are silently not drawn.

Test Plan:
- Reset, all-zero map, tank_en=0, start pulse at cycle k -> 4096 plot pulses, all colour 000; first plot x=0,y=0; last x=63,y=63; done at k+4865; busy low afterwards.
- Map walls at 0x20-0x2F, others 0 -> pixels y=8..11, x=0..63 are colour 111; all others 000; map_addr sequence 0x00..0xFF in order, one map_rd_en per cell.
- Wall at 0x21, tank0 and tank1 both at 0x21, tank_en=2'b11 -> x=4..7, y=8..11 colour 010 (tank0 wins over tank1 and wall); with tank_en=2'b10 the same pixels are 100.
- Change tank_pos from 0x00 to 0x55 mid-frame -> current frame still draws the tank at 0x00; next frame draws it at 0x55.
- start held high continuously -> done pulses every 4866 cycles; extra start pulses while busy produce no extra frames.
- resetn low during DRAW of cell 0x37 -> plot, busy and x/y drop to 0 asynchronously; after release, IDLE with no done; the next start renders a full frame beginning at 0x00.
